// File: rtl/gray_conv_pkg.sv
// gray_conv_pkg: shared types and helpers for the gray_conv_arbiter block
package gray_conv_pkg;
  localparam int MAXW = 32;
  localparam int MAXN = 8;
  localparam int IDXW = 3;
  typedef enum logic {IDLE, HOLD} state_t;
  typedef struct packed {
    logic            found;
    logic [IDXW-1:0] idx;
  } pick_t;
  function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic pick_t rr_pick(input logic [MAXN-1:0] req, input logic [IDXW-1:0] ptr, input int n);
    pick_t p;
    int k;
    p = '0;
    for (int i = 0; i < MAXN; i++) begin
      if (i < n) begin
        k = int'(ptr) + i;
        if (k >= n) k -= n;
        if (!p.found && req[k]) begin
          p.found = 1'b1;
          p.idx = IDXW'(k);
        end
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/gray_conv_arbiter_encoder.sv
// gray_encoder_w: combinational W-bit binary-to-Gray encoder
module gray_encoder_w
  import gray_conv_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);
  assign gray = W'(bin2gray(MAXW'(bin)));
endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin arbiter sharing one Gray encoder across NREQ requesters
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = 3,
  parameter  int CNTW = 16,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] bin_in,
  output logic [NREQ-1:0]   gnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_gray,
  output logic [W-1:0]      out_bin,
  output logic [IDW-1:0]    out_id,
  output logic [CNTW-1:0]   conv_count
);
  state_t         state, state_nxt;
  pick_t          pick;
  logic [IDW-1:0] rr_ptr;
  logic           can_accept, accept;
  logic [W-1:0]   sel_bin, sel_gray;
  always_comb begin
    pick = rr_pick(MAXN'(req), IDXW'(rr_ptr), NREQ);
    can_accept = (state == IDLE) || out_ready;
    accept = !rst && can_accept && pick.found;
    gnt = accept ? NREQ'(1) << pick.idx : '0;
    sel_bin = bin_in[pick.idx*W +: W];
    state_nxt = accept ? HOLD : (state == HOLD && out_ready) ? IDLE : state;
  end
  gray_encoder_w #(.W(W)) u_enc (.bin(sel_bin), .gray(sel_gray));
  assign out_valid = (state == HOLD);
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      conv_count <= '0;
      out_gray   <= '0;
      out_bin    <= '0;
      out_id     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        out_bin    <= sel_bin;
        out_gray   <= sel_gray;
        out_id     <= IDW'(pick.idx);
        rr_ptr     <= (pick.idx == IDXW'(NREQ-1)) ? '0 : IDW'(pick.idx + 3'd1);
        conv_count <= conv_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter: directed scoreboard bench for gray_conv_arbiter
module tb_gray_conv_arbiter;
  logic        clk = 1'b0, rst = 1'b1, out_ready = 1'b0;
  logic [3:0]  req = '0;
  logic [11:0] bin_in = '0;
  logic [3:0]  gnt, s_gnt;
  logic        out_valid, s_valid;
  logic [2:0]  out_gray, out_bin, s_gray, s_bin;
  logic [1:0]  out_id, s_id;
  logic [15:0] conv_count;
  logic [3:0]  s_count;
  typedef struct packed {
    logic [2:0] g;
    logic [2:0] b;
    logic [1:0] id;
  } rec_t;
  rec_t q[$];
  rec_t last = '0;
  logic mv = 1'b0;
  int   cnt = 0, passed = 0, total = 0;

  gray_conv_arbiter #(.NREQ(4), .W(3), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .req(req), .bin_in(bin_in), .gnt(gnt),
    .out_valid(out_valid), .out_ready(out_ready), .out_gray(out_gray),
    .out_bin(out_bin), .out_id(out_id), .conv_count(conv_count));

  gray_conv_arbiter #(.NREQ(4), .W(3), .CNTW(4)) dut_small (
    .clk(clk), .rst(rst), .req(req), .bin_in(bin_in), .gnt(s_gnt),
    .out_valid(s_valid), .out_ready(out_ready), .out_gray(s_gray),
    .out_bin(s_bin), .out_id(s_id), .conv_count(s_count));

  always #5 clk = ~clk;

  function automatic logic [2:0] enc(input logic [2:0] b);
    logic [2:0] g;
    g[2] = b[2];
    for (int i = 0; i < 2; i++) g[i] = b[i+1] ^ b[i];
    return g;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input logic r_rst, input logic [3:0] r, input logic rdy, input logic [3:0] eg);
    rst = r_rst;
    req = r;
    out_ready = rdy;
    #1;
    chk("gnt", 32'(gnt), 32'(eg));
    for (int k = 0; k < 4; k++)
      if (eg[k]) q.push_back('{enc(bin_in[k*3 +: 3]), bin_in[k*3 +: 3], 2'(k)});
    @(posedge clk);
    #1;
    if (r_rst) begin
      mv = 1'b0;
      cnt = 0;
      q.delete();
      last = '0;
    end else if (eg != 0) begin
      mv = 1'b1;
      cnt++;
    end else if (rdy) mv = 1'b0;
    if (q.size() > 0) last = q.pop_front();
    chk("out_valid", 32'(out_valid), 32'(mv));
    chk("conv_count", 32'(conv_count), 32'(cnt % 65536));
    chk("conv_count_w4", 32'(s_count), 32'(cnt % 16));
    chk("out_gray", 32'(out_gray), 32'(last.g));
    chk("out_bin", 32'(out_bin), 32'(last.b));
    chk("out_id", 32'(out_id), 32'(last.id));
  endtask

  initial begin
    bin_in = {3'b001, 3'b101, 3'b010, 3'b110};
    step(1, 4'b1111, 1, 4'b0000);
    step(1, 4'b1111, 1, 4'b0000);
    step(0, 4'b1111, 1, 4'b0001);
    step(0, 4'b0000, 1, 4'b0000);
    step(0, 4'b0100, 1, 4'b0100);
    step(0, 4'b0000, 1, 4'b0000);
    step(1, 4'b0000, 1, 4'b0000);
    bin_in = {3'b111, 3'b110, 3'b011, 3'b000};
    step(0, 4'b1111, 1, 4'b0001);
    step(0, 4'b1111, 1, 4'b0010);
    step(0, 4'b1111, 1, 4'b0100);
    step(0, 4'b1111, 1, 4'b1000);
    step(0, 4'b1111, 1, 4'b0001);
    for (int i = 0; i < 5; i++) step(0, 4'b1000, 0, 4'b0000);
    step(0, 4'b1000, 1, 4'b1000);
    step(0, 4'b0000, 1, 4'b0000);
    for (int v = 0; v < 8; v++) begin
      bin_in[5:3] = 3'(v);
      step(0, 4'b0010, 1, 4'b0010);
    end
    step(0, 4'b0000, 1, 4'b0000);
    step(0, 4'b0001, 1, 4'b0001);
    step(0, 4'b0000, 0, 4'b0000);
    step(1, 4'b0000, 0, 4'b0000);
    step(0, 4'b1010, 1, 4'b0010);
    step(0, 4'b0000, 1, 4'b0000);
    step(1, 4'b0000, 1, 4'b0000);
    for (int i = 0; i < 16; i++) step(0, 4'b1111, 1, 4'(1 << (i % 4)));
    chk("wrap_w4", 32'(s_count), 32'd0);
    step(0, 4'b0000, 1, 4'b0000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
